// File: rtl/led_sequencer.sv
// LED sequencer: lights one game LED (or flashes all four) for a speed-dependent
// on-time, blanks for a fixed gap, and pulses show_done when the request is finished.
// Optional build macro: LED_ACTIVE_LOW_EN inverts all four LED outputs (lit = 0).
module led_sequencer #(
  parameter int unsigned COLOR_CODEFY_W = 2,
  parameter int unsigned ON_FAST_CYCLES = 12_500_000,
  parameter int unsigned ON_SLOW_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 5_000_000,
  parameter int unsigned FLASH_COUNT    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      speed,
  input  logic                      show_valid,
  input  logic [COLOR_CODEFY_W-1:0] show_color,
  input  logic                      show_all,
  output logic                      show_ready,
  output logic                      show_done,
  output logic                      led_green,
  output logic                      led_red,
  output logic                      led_blue,
  output logic                      led_yellow
);

  localparam int unsigned LED_W   = 4;
  localparam int unsigned MAX_ON  = (ON_SLOW_CYCLES > ON_FAST_CYCLES) ? ON_SLOW_CYCLES : ON_FAST_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_ON > GAP_CYCLES) ? MAX_ON : GAP_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);
  localparam int unsigned FLASH_W = $clog2(FLASH_COUNT + 1);

  // LED register holds physical pin levels, so the polarity lives in one constant.
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LED_OFF = '1;
`else
  localparam logic [LED_W-1:0] LED_OFF = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [FLASH_W-1:0]        flash_q, flash_d;
  logic [COLOR_CODEFY_W-1:0] color_q, color_d;
  logic                      all_q, all_d;
  logic                      fast_q, fast_d;
  logic [LED_W-1:0]          led_q, led_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;

  // Timer reload value for the on-phase at the given speed.
  function automatic logic [TIMER_W-1:0] on_load(input logic fast);
    return fast ? TIMER_W'(ON_FAST_CYCLES - 1) : TIMER_W'(ON_SLOW_CYCLES - 1);
  endfunction

  // Physical LED levels for the lit phase: {yellow, blue, red, green}.
  function automatic logic [LED_W-1:0] lit_leds(input logic all,
                                                input logic [COLOR_CODEFY_W-1:0] color);
    logic [LED_W-1:0] act;
    act = '0;
    if (all) begin
      act = '1;
    end else begin
      case (color)
        COLOR_CODEFY_W'(0): act = 4'b0001;
        COLOR_CODEFY_W'(1): act = 4'b0010;
        COLOR_CODEFY_W'(2): act = 4'b0100;
        COLOR_CODEFY_W'(3): act = 4'b1000;
        default:            act = '0;
      endcase
    end
    return act ^ LED_OFF;
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      flash_q <= '0;
      color_q <= '0;
      all_q   <= 1'b0;
      fast_q  <= 1'b0;
      led_q   <= LED_OFF;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flash_q <= flash_d;
      color_q <= color_d;
      all_q   <= all_d;
      fast_q  <= fast_d;
      led_q   <= led_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flash_d = flash_q;
    color_d = color_q;
    all_d   = all_q;
    fast_d  = fast_q;
    led_d   = led_q;
    ready_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        led_d   = LED_OFF;
        if (show_valid && ready_q) begin
          color_d = show_color;
          all_d   = show_all;
          fast_d  = speed;
          timer_d = on_load(speed);
          flash_d = '0;
          led_d   = lit_leds(show_all, show_color);
          ready_d = 1'b0;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (timer_q == '0) begin
          led_d   = LED_OFF;
          timer_d = TIMER_W'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_GAP: begin
        led_d = LED_OFF;
        if (timer_q == '0) begin
          if (!all_q || flash_q == FLASH_W'(FLASH_COUNT - 1)) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            flash_d = flash_q + FLASH_W'(1);
            timer_d = on_load(fast_q);
            led_d   = lit_leds(all_q, color_q);
            state_d = S_ON;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        led_d   = LED_OFF;
        state_d = S_IDLE;
      end
    endcase
  end

  assign show_ready = ready_q;
  assign show_done  = done_q;
  assign led_green  = led_q[0];
  assign led_red    = led_q[1];
  assign led_blue   = led_q[2];
  assign led_yellow = led_q[3];

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with short timing parameters.
// Expected per-cycle outputs are queued when a request is driven and popped each cycle.
module tb_led_sequencer;

  localparam int unsigned ON_FAST = 4;
  localparam int unsigned ON_SLOW = 8;
  localparam int unsigned GAP     = 2;
  localparam int unsigned FLASH   = 3;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [3:0] OFF = 4'hF;
`else
  localparam logic [3:0] OFF = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       speed = 1'b0;
  logic       show_valid = 1'b0;
  logic [1:0] show_color = 2'b00;
  logic       show_all = 1'b0;
  logic       show_ready, show_done;
  logic       led_green, led_red, led_blue, led_yellow;

  int errors = 0;
  int checks = 0;

  // Expected {ready, done, yellow, blue, red, green} per cycle.
  logic [5:0] exp_q[$];

  led_sequencer #(
    .COLOR_CODEFY_W(2),
    .ON_FAST_CYCLES(ON_FAST),
    .ON_SLOW_CYCLES(ON_SLOW),
    .GAP_CYCLES    (GAP),
    .FLASH_COUNT   (FLASH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .speed     (speed),
    .show_valid(show_valid),
    .show_color(show_color),
    .show_all  (show_all),
    .show_ready(show_ready),
    .show_done (show_done),
    .led_green (led_green),
    .led_red   (led_red),
    .led_blue  (led_blue),
    .led_yellow(led_yellow)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {show_ready, show_done, led_yellow, led_blue, led_red, led_green};
  endfunction

  function automatic logic [3:0] lit(input logic all, input logic [1:0] c);
    logic [3:0] v;
    logic [3:0] one;
    one = 4'b0001;
    v = all ? 4'hF : (one << c);
    return v ^ OFF;
  endfunction

  // Timeline of one request: on-phase, gap, then the done/ready cycle.
  function automatic void push_req(input logic all, input logic [1:0] c, input logic spd);
    int on;
    int reps;
    on   = spd ? int'(ON_FAST) : int'(ON_SLOW);
    reps = all ? int'(FLASH) : 1;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < on; i++) exp_q.push_back({2'b00, lit(all, c)});
      for (int i = 0; i < int'(GAP); i++) exp_q.push_back({2'b00, OFF});
    end
    exp_q.push_back({2'b11, OFF});
  endfunction

  // Present a request for one edge; returns just after the accepting edge.
  task automatic accept(input logic all, input logic [1:0] c, input logic spd);
    show_valid = 1'b1;
    show_all   = all;
    show_color = c;
    speed      = spd;
    push_req(all, c, spd);
    @(posedge clk);
    #1;
    show_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    #1 rst_n = 1'b0;
    #2;
    e = {2'b10, OFF};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs(), e);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    show_color = 2'b11;
    speed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL idle_no_valid cycle %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_color_fast();
    logic [5:0] e;
    int n;
    accept(1'b0, 2'b10, 1'b1);
    exp_q.push_back({2'b10, OFF});
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL color_fast cycle %0d: got %b want %b", n, obs(), e);
      end
      n++;
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_color_slow();
    logic [5:0] e;
    int n;
    accept(1'b0, 2'b11, 1'b0);
    exp_q.push_back({2'b10, OFF});
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL color_slow cycle %0d: got %b want %b", n, obs(), e);
      end
      if (n == 2) begin
        speed      = 1'b1;
        show_color = 2'b00;
      end
      n++;
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_flash_all();
    logic [5:0] e;
    int n;
    accept(1'b1, 2'b01, 1'b1);
    exp_q.push_back({2'b10, OFF});
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL flash_all cycle %0d: got %b want %b", n, obs(), e);
      end
      n++;
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_ignore_and_reset();
    logic [5:0] e;
    int n;
    accept(1'b0, 2'b00, 1'b1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL ignore_busy cycle %0d: got %b want %b", n, obs(), e);
      end
      if (n == 1) begin
        show_valid = 1'b1;
        show_all   = 1'b1;
        show_color = 2'b01;
      end
      if (n == 3) begin
        show_valid = 1'b0;
        show_all   = 1'b0;
        rst_n      = 1'b0;
        #1;
        e = {2'b10, OFF};
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL async_reset_mid_on: got %b want %b", obs(), e);
        end
        exp_q.delete();
      end
      n++;
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk) rst_n = 1'b1;
    e = {2'b10, OFF};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL after_reset_idle cycle %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    int n;
    logic second;
    second = 1'b0;
    accept(1'b0, 2'b00, 1'b1);
    n = 0;
    while (exp_q.size() > 0) begin
      show_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", n, obs(), e);
      end
      if (e[4] && !second) begin
        second     = 1'b1;
        show_valid = 1'b1;
        show_all   = 1'b0;
        show_color = 2'b01;
        speed      = 1'b1;
        push_req(1'b0, 2'b01, 1'b1);
        exp_q.push_back({2'b10, OFF});
      end
      n++;
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    show_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_color_fast();
    test_color_slow();
    test_flash_all();
    test_ignore_and_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
